// File: rtl/conv_stream_pkg.sv
// Shared types and helpers for the convolution operand streamer.
//   state_e : streamer control states
//   idx_w   : width of a loop counter that must hold values 0..n-1
package conv_stream_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    DRAIN  = 2'd2
  } state_e;

  // Counter width for a loop of n iterations; never narrower than one bit.
  function automatic int unsigned idx_w(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/conv_operand_streamer_if.sv
// Operand handshake bundle between the streamer and the compute chip.
//   a_* : activation operand channel (valid/ready, data, zero flag)
//   b_* : weight operand channel (valid/ready, data, zero flag)
//   master : streamer side, slave : compute side
interface conv_operand_streamer_if #(
  parameter int unsigned DATA_W = 16
) ();

  logic [DATA_W-1:0] a_input;
  logic              a_zero_flag;
  logic              a_valid;
  logic              a_ready;
  logic [DATA_W-1:0] b_input;
  logic              b_zero_flag;
  logic              b_valid;
  logic              b_ready;

  modport master (
    output a_input, a_zero_flag, a_valid, b_input, b_zero_flag, b_valid,
    input  a_ready, b_ready
  );

  modport slave (
    input  a_input, a_zero_flag, a_valid, b_input, b_zero_flag, b_valid,
    output a_ready, b_ready
  );

endinterface

// File: rtl/operand_fifo2.sv
// Two-entry show-ahead FIFO; head is the oldest entry whenever count != 0.
//   push/push_data : write one entry
//   pop            : drop the head entry (caller guarantees count != 0)
//   head, count    : registered head entry and occupancy
module operand_fifo2 #(
  parameter int unsigned WIDTH = 17
) (
  input  logic             clk,
  input  logic             arst_n_in,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic [1:0]       count
);

  logic [1:0][WIDTH-1:0] mem_q, mem_d;
  logic                  wr_ptr_q, wr_ptr_d;
  logic                  rd_ptr_q, rd_ptr_d;
  logic [1:0]            count_q, count_d;

  // Pointer/occupancy update.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push) begin
      mem_d[wr_ptr_q] = push_data;
      wr_ptr_d        = ~wr_ptr_q;
    end
    if (pop) begin
      rd_ptr_d = ~rd_ptr_q;
    end
    count_d = count_q + 2'(push) - 2'(pop);
  end

  always_ff @(posedge clk or negedge arst_n_in) begin
    if (!arst_n_in) begin
      mem_q    <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign head  = mem_q[rd_ptr_q];
  assign count = count_q;

endmodule

// File: rtl/conv_operand_streamer.sv
// Walks the y/x/co/ky/kx/ci loop nest, reads activations and weights from
// their SRAMs and streams them to the compute chip with zero padding and
// zero-skip flags.
//   clk, arst_n_in     : clock, async active-low reset
//   start              : launch one layer (sampled only when idle)
//   running, done      : busy indicator and end-of-layer pulse
//   fm_mem_* / w_mem_* : SRAM read ports (one-cycle read latency)
//   op                 : a/b operand handshake channels
module conv_operand_streamer
  import conv_stream_pkg::*;
#(
  parameter int unsigned IO_DATA_WIDTH      = 16,
  parameter int unsigned FEATURE_MAP_WIDTH  = 1024,
  parameter int unsigned FEATURE_MAP_HEIGHT = 1024,
  parameter int unsigned INPUT_NB_CHANNELS  = 64,
  parameter int unsigned OUTPUT_NB_CHANNELS = 64,
  parameter int unsigned KERNEL_SIZE        = 3,
  parameter int unsigned FM_ADDR_W = $clog2(FEATURE_MAP_WIDTH*FEATURE_MAP_HEIGHT*INPUT_NB_CHANNELS),
  parameter int unsigned W_ADDR_W  = $clog2(OUTPUT_NB_CHANNELS*KERNEL_SIZE*KERNEL_SIZE*INPUT_NB_CHANNELS)
) (
  input  logic                     clk,
  input  logic                     arst_n_in,
  input  logic                     start,
  output logic                     running,
  output logic                     done,
  output logic [FM_ADDR_W-1:0]     fm_mem_read_addr,
  output logic                     fm_mem_read_en,
  input  logic [IO_DATA_WIDTH-1:0] fm_mem_qout,
  output logic [W_ADDR_W-1:0]      w_mem_read_addr,
  output logic                     w_mem_read_en,
  input  logic [IO_DATA_WIDTH-1:0] w_mem_qout,
  conv_operand_streamer_if.master  op
);

  localparam int unsigned YW   = idx_w(FEATURE_MAP_HEIGHT);
  localparam int unsigned XW   = idx_w(FEATURE_MAP_WIDTH);
  localparam int unsigned COW  = idx_w(OUTPUT_NB_CHANNELS);
  localparam int unsigned KW   = idx_w(KERNEL_SIZE);
  localparam int unsigned CIW  = idx_w(INPUT_NB_CHANNELS);
  localparam int unsigned HALF = KERNEL_SIZE / 2;
  localparam int unsigned SW   = YW + XW + KW + 2;
  localparam int unsigned AW   = FM_ADDR_W + SW + 2;
  localparam int unsigned WA   = W_ADDR_W + 2;
  localparam int unsigned EW   = IO_DATA_WIDTH + 1;

  state_e              state_q, state_d;
  logic [YW-1:0]       y_q, y_d;
  logic [XW-1:0]       x_q, x_d;
  logic [COW-1:0]      co_q, co_d;
  logic [KW-1:0]       ky_q, ky_d;
  logic [KW-1:0]       kx_q, kx_d;
  logic [CIW-1:0]      ci_q, ci_d;
  logic                inflight_q, inflight_d;
  logic                pad_q, pad_d;
  logic                running_q, running_d;
  logic                done_q, done_d;

  logic [SW-1:0]       ys, xs, yi, xi;
  logic [AW-1:0]       fm_full;
  logic [WA-1:0]       w_full;
  logic                pad, last_elem, issue;
  logic                a_pop, b_pop, a_room, b_room;
  logic                a_zero, b_zero;
  logic [1:0]          a_count, b_count;
  logic [EW-1:0]       a_push_data, b_push_data, a_head, b_head;

  // Padding detection and address arithmetic for the current element.
  always_comb begin
    ys  = SW'(y_q) + SW'(ky_q);
    xs  = SW'(x_q) + SW'(kx_q);
    pad = (ys < SW'(HALF)) || (ys >= SW'(FEATURE_MAP_HEIGHT + HALF)) ||
          (xs < SW'(HALF)) || (xs >= SW'(FEATURE_MAP_WIDTH + HALF));
    yi  = ys - SW'(HALF);
    xi  = xs - SW'(HALF);
    fm_full = (AW'(yi) * AW'(FEATURE_MAP_WIDTH) + AW'(xi)) * AW'(INPUT_NB_CHANNELS)
            + AW'(ci_q);
    w_full  = ((WA'(co_q) * WA'(KERNEL_SIZE) + WA'(ky_q)) * WA'(KERNEL_SIZE) + WA'(kx_q))
            * WA'(INPUT_NB_CHANNELS) + WA'(ci_q);
    last_elem = (ci_q == CIW'(INPUT_NB_CHANNELS - 1)) && (kx_q == KW'(KERNEL_SIZE - 1)) &&
                (ky_q == KW'(KERNEL_SIZE - 1)) && (co_q == COW'(OUTPUT_NB_CHANNELS - 1)) &&
                (x_q == XW'(FEATURE_MAP_WIDTH - 1)) && (y_q == YW'(FEATURE_MAP_HEIGHT - 1));
  end

  // Credit check: a slot issued now must still fit once its data lands.
  assign a_pop  = op.a_valid && op.a_ready;
  assign b_pop  = op.b_valid && op.b_ready;
  assign a_room = (3'(a_count) + 3'(inflight_q)) < (3'd2 + 3'(a_pop));
  assign b_room = (3'(b_count) + 3'(inflight_q)) < (3'd2 + 3'(b_pop));

  // Control FSM and loop-counter advance (ci innermost).
  always_comb begin
    state_d    = state_q;
    y_d        = y_q;
    x_d        = x_q;
    co_d       = co_q;
    ky_d       = ky_q;
    kx_d       = kx_q;
    ci_d       = ci_q;
    inflight_d = 1'b0;
    pad_d      = 1'b0;
    issue      = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = STREAM;
          y_d  = '0;
          x_d  = '0;
          co_d = '0;
          ky_d = '0;
          kx_d = '0;
          ci_d = '0;
        end
      end
      STREAM: begin
        if (a_room && b_room) begin
          issue      = 1'b1;
          inflight_d = 1'b1;
          pad_d      = pad;
          ci_d       = ci_q + CIW'(1);
          if (ci_q == CIW'(INPUT_NB_CHANNELS - 1)) begin
            ci_d = '0;
            kx_d = kx_q + KW'(1);
            if (kx_q == KW'(KERNEL_SIZE - 1)) begin
              kx_d = '0;
              ky_d = ky_q + KW'(1);
              if (ky_q == KW'(KERNEL_SIZE - 1)) begin
                ky_d = '0;
                co_d = co_q + COW'(1);
                if (co_q == COW'(OUTPUT_NB_CHANNELS - 1)) begin
                  co_d = '0;
                  x_d  = x_q + XW'(1);
                  if (x_q == XW'(FEATURE_MAP_WIDTH - 1)) begin
                    x_d = '0;
                    y_d = y_q + YW'(1);
                    if (y_q == YW'(FEATURE_MAP_HEIGHT - 1)) begin
                      y_d = '0;
                    end
                  end
                end
              end
            end
          end
          if (last_elem) begin
            state_d = DRAIN;
          end
        end
      end
      DRAIN: begin
        if ((a_count == 2'd0) && (b_count == 2'd0) && !inflight_q) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    running_d = (state_d != IDLE);
    done_d    = (state_q == DRAIN) && (state_d == IDLE);
  end

  always_ff @(posedge clk or negedge arst_n_in) begin
    if (!arst_n_in) begin
      state_q    <= IDLE;
      y_q        <= '0;
      x_q        <= '0;
      co_q       <= '0;
      ky_q       <= '0;
      kx_q       <= '0;
      ci_q       <= '0;
      inflight_q <= 1'b0;
      pad_q      <= 1'b0;
      running_q  <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      y_q        <= y_d;
      x_q        <= x_d;
      co_q       <= co_d;
      ky_q       <= ky_d;
      kx_q       <= kx_d;
      ci_q       <= ci_d;
      inflight_q <= inflight_d;
      pad_q      <= pad_d;
      running_q  <= running_d;
      done_q     <= done_d;
    end
  end

  // Addresses are held at zero outside an issue so idle outputs stay quiet.
  assign fm_mem_read_en   = issue && !pad;
  assign fm_mem_read_addr = fm_mem_read_en ? FM_ADDR_W'(fm_full) : '0;
  assign w_mem_read_en    = issue;
  assign w_mem_read_addr  = issue ? W_ADDR_W'(w_full) : '0;
  assign running          = running_q;
  assign done             = done_q;

  // Returning read data; padded slots carry no SRAM data.
  always_comb begin
    a_zero      = pad_q || (fm_mem_qout == IO_DATA_WIDTH'(0));
    b_zero      = (w_mem_qout == IO_DATA_WIDTH'(0));
    a_push_data = {a_zero, a_zero ? IO_DATA_WIDTH'(0) : fm_mem_qout};
    b_push_data = {b_zero, b_zero ? IO_DATA_WIDTH'(0) : w_mem_qout};
  end

  operand_fifo2 #(.WIDTH(EW)) u_a_fifo (
    .clk       (clk),
    .arst_n_in (arst_n_in),
    .push      (inflight_q),
    .push_data (a_push_data),
    .pop       (a_pop),
    .head      (a_head),
    .count     (a_count)
  );

  operand_fifo2 #(.WIDTH(EW)) u_b_fifo (
    .clk       (clk),
    .arst_n_in (arst_n_in),
    .push      (inflight_q),
    .push_data (b_push_data),
    .pop       (b_pop),
    .head      (b_head),
    .count     (b_count)
  );

  assign op.a_valid     = (a_count != 2'd0);
  assign op.a_input     = a_head[IO_DATA_WIDTH-1:0];
  assign op.a_zero_flag = a_head[IO_DATA_WIDTH];
  assign op.b_valid     = (b_count != 2'd0);
  assign op.b_input     = b_head[IO_DATA_WIDTH-1:0];
  assign op.b_zero_flag = b_head[IO_DATA_WIDTH];

endmodule

// File: tb/tb_conv_operand_streamer.sv
// Self-checking bench for conv_operand_streamer in the W=H=4, CIN=COUT=2, K=3
// configuration, compared against a loop-nest reference model.
`timescale 1ns/1ps
module tb_conv_operand_streamer;

  localparam int unsigned DW  = 16;
  localparam int unsigned FW  = 4;
  localparam int unsigned FH  = 4;
  localparam int unsigned CI  = 2;
  localparam int unsigned CO  = 2;
  localparam int unsigned KS  = 3;
  localparam int unsigned N   = FW*FH*CO*KS*KS*CI;
  localparam int unsigned FAW = $clog2(FW*FH*CI);
  localparam int unsigned WAW = $clog2(CO*KS*KS*CI);

  logic           clk = 1'b0;
  logic           arst_n_in;
  logic           start;
  logic           running, done;
  logic [FAW-1:0] fm_addr;
  logic           fm_en;
  logic [DW-1:0]  fm_q;
  logic [WAW-1:0] w_addr;
  logic           w_en;
  logic [DW-1:0]  w_q;

  conv_operand_streamer_if #(.DATA_W(DW)) op ();

  conv_operand_streamer #(
    .IO_DATA_WIDTH(DW), .FEATURE_MAP_WIDTH(FW), .FEATURE_MAP_HEIGHT(FH),
    .INPUT_NB_CHANNELS(CI), .OUTPUT_NB_CHANNELS(CO), .KERNEL_SIZE(KS),
    .FM_ADDR_W(FAW), .W_ADDR_W(WAW)
  ) dut (
    .clk(clk), .arst_n_in(arst_n_in), .start(start), .running(running), .done(done),
    .fm_mem_read_addr(fm_addr), .fm_mem_read_en(fm_en), .fm_mem_qout(fm_q),
    .w_mem_read_addr(w_addr), .w_mem_read_en(w_en), .w_mem_qout(w_q),
    .op(op)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // SRAM models with one-cycle read latency.
  logic [DW-1:0] fm_mem [0:FW*FH*CI-1];
  logic [DW-1:0] w_mem  [0:63];
  always @(posedge clk) begin
    if (fm_en) fm_q <= fm_mem[fm_addr];
    if (w_en)  w_q  <= w_mem[w_addr];
  end

  // Reference stream, built from the loop nest.
  logic [DW:0]  exp_a  [N];
  logic [DW:0]  exp_b  [N];
  logic [WAW-1:0] exp_w [N];
  logic [FAW:0] exp_fm [N];

  int n_pass = 0;
  int n_checks = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got=%0h expected=%0h", tag, got, want);
  endtask

  // Ready drivers.
  bit rand_a = 0;
  bit b_stall = 0;
  int t0 = 0;
  initial begin
    op.a_ready = 1'b1;
    op.b_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      op.a_ready = rand_a ? 1'($urandom_range(0, 1)) : 1'b1;
      op.b_ready = !(b_stall && (cyc - t0 >= 10) && (cyc - t0 <= 19));
    end
  end

  // Monitor state.
  logic [DW:0]    obs_a [N];
  logic [DW:0]    obs_b [N];
  logic [WAW-1:0] obs_w [N];
  logic [FAW:0]   obs_fm [N];
  int n_iss, n_a, n_b, stray_fm, stab_err, max_bl, stall_reads, n_done;
  int first_va, first_a_cyc, last_a_cyc, first_b_cyc, last_b_cyc;
  bit done_running, done_prev_running, prev_running;
  bit a_hold, b_hold;
  logic [DW:0] a_hold_v, b_hold_v;

  task automatic clear_mon();
    n_iss = 0; n_a = 0; n_b = 0; stray_fm = 0; stab_err = 0; max_bl = 0;
    stall_reads = 0; n_done = 0; first_va = -1; first_a_cyc = -1; first_b_cyc = -1;
    last_a_cyc = 0; last_b_cyc = 0; done_running = 1'b0; done_prev_running = 1'b0;
    prev_running = 1'b0; a_hold = 1'b0; b_hold = 1'b0; a_hold_v = '0; b_hold_v = '0;
  endtask

  always @(negedge clk) begin
    if (arst_n_in) begin
      if (w_en) begin
        if (n_iss < N) begin
          obs_w[n_iss]  = w_addr;
          obs_fm[n_iss] = fm_en ? {1'b1, fm_addr} : '0;
        end
        n_iss++;
        if (!op.b_ready) stall_reads++;
      end else if (fm_en) begin
        stray_fm++;
      end
      if (op.a_valid && first_va < 0) first_va = cyc;
      if (a_hold && (!op.a_valid || {op.a_zero_flag, op.a_input} != a_hold_v)) stab_err++;
      if (b_hold && (!op.b_valid || {op.b_zero_flag, op.b_input} != b_hold_v)) stab_err++;
      a_hold = op.a_valid && !op.a_ready;
      b_hold = op.b_valid && !op.b_ready;
      a_hold_v = {op.a_zero_flag, op.a_input};
      b_hold_v = {op.b_zero_flag, op.b_input};
      if (op.a_valid && op.a_ready) begin
        if (n_a < N) obs_a[n_a] = {op.a_zero_flag, op.a_input};
        if (first_a_cyc < 0) first_a_cyc = cyc;
        last_a_cyc = cyc;
        n_a++;
      end
      if (op.b_valid && op.b_ready) begin
        if (n_b < N) obs_b[n_b] = {op.b_zero_flag, op.b_input};
        if (first_b_cyc < 0) first_b_cyc = cyc;
        last_b_cyc = cyc;
        n_b++;
      end
      if (n_iss - n_a > max_bl) max_bl = n_iss - n_a;
      if (n_iss - n_b > max_bl) max_bl = n_iss - n_b;
      if (done) begin
        n_done++;
        done_running = running;
        done_prev_running = prev_running;
      end
      prev_running = running;
    end
  end

  task automatic pulse_start();
    @(posedge clk); #1;
    start = 1'b1;
    t0 = cyc;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int i;
    for (i = 0; i < 20000 && n_done == 0; i++) @(posedge clk);
    chk({tag, " done_seen"}, 32'(n_done != 0), 32'd1);
    repeat (10) @(posedge clk);
  endtask

  task automatic check_run(input string tag);
    for (int k = 0; k < N; k++) begin
      chk($sformatf("%s a[%0d]", tag, k), 32'(obs_a[k]), 32'(exp_a[k]));
      chk($sformatf("%s b[%0d]", tag, k), 32'(obs_b[k]), 32'(exp_b[k]));
      chk($sformatf("%s waddr[%0d]", tag, k), 32'(obs_w[k]), 32'(exp_w[k]));
      chk($sformatf("%s fmrd[%0d]", tag, k), 32'(obs_fm[k]), 32'(exp_fm[k]));
    end
    chk({tag, " a_xfers"}, 32'(n_a), 32'(N));
    chk({tag, " b_xfers"}, 32'(n_b), 32'(N));
    chk({tag, " issues"}, 32'(n_iss), 32'(N));
    chk({tag, " stray_fm_reads"}, 32'(stray_fm), 32'd0);
    chk({tag, " handshake_stable"}, 32'(stab_err), 32'd0);
    chk({tag, " occupancy_le2"}, 32'(max_bl <= 2), 32'd1);
    chk({tag, " done_pulses"}, 32'(n_done), 32'd1);
    chk({tag, " running_at_done"}, 32'(done_running), 32'd0);
    chk({tag, " running_before_done"}, 32'(done_prev_running), 32'd1);
    chk({tag, " valid_after_done"}, 32'({op.a_valid, op.b_valid}), 32'd0);
  endtask

  function automatic logic [31:0] all_outputs();
    return 32'(running | done | fm_en | w_en | op.a_valid | op.b_valid |
               op.a_zero_flag | op.b_zero_flag | (|op.a_input) | (|op.b_input) |
               (|fm_addr) | (|w_addr));
  endfunction

  initial begin : main
    logic [31:0] idle_or;
    int kz;
    arst_n_in = 1'b0;
    start = 1'b0;
    clear_mon();

    // Memory contents: nonzero except a few chosen zero words.
    for (int i = 0; i < FW*FH*CI; i++) fm_mem[i] = 16'($urandom_range(1, 16'hFFFF));
    for (int i = 0; i < 64; i++) w_mem[i] = 16'($urandom_range(1, 16'hFFFF));
    w_mem[4]  = '0;
    fm_mem[5] = '0;
    fm_mem[20] = '0;

    for (int y = 0; y < FH; y++)
      for (int x = 0; x < FW; x++)
        for (int co = 0; co < CO; co++)
          for (int ky = 0; ky < KS; ky++)
            for (int kx = 0; kx < KS; kx++)
              for (int ci = 0; ci < CI; ci++) begin
                int k, yi, xi, fa, wa;
                bit p;
                logic [DW-1:0] av, bv;
                k  = (((((y*FW + x)*CO + co)*KS + ky)*KS + kx)*CI) + ci;
                yi = y + ky - KS/2;
                xi = x + kx - KS/2;
                p  = (yi < 0) || (yi >= FH) || (xi < 0) || (xi >= FW);
                fa = p ? 0 : (yi*FW + xi)*CI + ci;
                wa = ((co*KS + ky)*KS + kx)*CI + ci;
                av = p ? '0 : fm_mem[fa];
                bv = w_mem[wa];
                exp_a[k]  = {(av == '0), av};
                exp_b[k]  = {(bv == '0), bv};
                exp_w[k]  = WAW'(wa);
                exp_fm[k] = p ? '0 : {1'b1, FAW'(fa)};
              end

    // Reset state and quiet idle.
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_outputs", all_outputs(), 32'd0);
    @(posedge clk); #1;
    arst_n_in = 1'b1;
    idle_or = '0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      idle_or = idle_or | all_outputs();
    end
    chk("idle_20_cycles", idle_or, 32'd0);

    // Run 1: readies high.
    clear_mon();
    pulse_start();
    wait_done("run1");
    check_run("run1");
    chk("first_valid_latency", 32'(first_va - t0), 32'd3);
    chk("first_a_padded", 32'(obs_a[0]), 32'h10000);
    chk("first_w_addr", 32'(obs_w[0]), 32'd0);
    chk("first_fm_read_en", 32'(obs_fm[0][FAW]), 32'd0);
    chk("a_back_to_back", 32'(last_a_cyc - first_a_cyc), 32'(N - 1));
    chk("b_back_to_back", 32'(last_b_cyc - first_b_cyc), 32'(N - 1));
    chk("elem189_w_addr", 32'(obs_w[189]), 32'd9);
    chk("elem189_fm_addr", 32'(obs_fm[189]), 32'({1'b1, 5'd11}));
    chk("elem189_a_value", 32'(obs_a[189]), 32'({1'b0, fm_mem[11]}));
    chk("b_zero_waddr4", 32'(obs_b[4]), 32'h10000);
    kz = 0;
    for (int k = N - 1; k >= 0; k--) if (exp_fm[k] == {1'b1, FAW'(5)}) kz = k;
    chk("a_zero_fmaddr5", 32'(obs_a[kz]), 32'h10000);

    // Run 2: random a_ready, b stalled for 10 cycles, stray start mid-stream.
    clear_mon();
    rand_a = 1'b1;
    b_stall = 1'b1;
    pulse_start();
    repeat (200) @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    wait_done("run2");
    check_run("run2");
    chk("reads_stall_on_b", 32'(stall_reads <= 2), 32'd1);
    rand_a = 1'b0;
    b_stall = 1'b0;

    // Run 3: reset at transfer 100, then a full restart.
    clear_mon();
    pulse_start();
    begin
      int i;
      for (i = 0; i < 5000 && n_a < 100; i++) @(negedge clk);
      chk("reached_transfer_100", 32'(n_a >= 100), 32'd1);
    end
    #2 arst_n_in = 1'b0;
    #1 chk("abort_outputs", all_outputs(), 32'd0);
    repeat (3) @(posedge clk);
    #1 arst_n_in = 1'b1;
    clear_mon();
    pulse_start();
    wait_done("run3");
    check_run("run3");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/conv_operand_streamer.md
Name: conv_operand_streamer

Overview:
- Producer side of the accelerator's operand interface. Walks the convolution loop nest and reads activations from a feature-map SRAM and weights from a weight SRAM.
- Drives a_input/a_valid/a_zero_flag and b_input/b_valid/b_zero_flag into the compute chip, honouring a_ready/b_ready independently.
- Generates zero-padding at feature-map borders and zero-skip flags.
- Sits between the operand memories and the chip top.

Parameters:
IO_DATA_WIDTH, 16, operand width
FEATURE_MAP_WIDTH, 1024, input/output map width (stride 1, same padding)
FEATURE_MAP_HEIGHT, 1024, map height
INPUT_NB_CHANNELS, 64, input channels
OUTPUT_NB_CHANNELS, 64, output channels
KERNEL_SIZE, 3, odd kernel size
FM_ADDR_W, $clog2(FEATURE_MAP_WIDTH*FEATURE_MAP_HEIGHT*INPUT_NB_CHANNELS), feature-map address width
W_ADDR_W, $clog2(OUTPUT_NB_CHANNELS*KERNEL_SIZE*KERNEL_SIZE*INPUT_NB_CHANNELS), weight address width

Ports:
clk  in  1  clock
arst_n_in  in  1  asynchronous reset, active low
start  in  1  begin one full layer stream; sampled only in IDLE
running  out  1  high in STREAM and DRAIN
done  out  1  one-cycle pulse when the last b and a transfers complete
fm_mem_read_addr  out  FM_ADDR_W  activation address
fm_mem_read_en  out  1  activation read strobe
fm_mem_qout  in  IO_DATA_WIDTH  activation data, valid one cycle after read_en
w_mem_read_addr  out  W_ADDR_W  weight address
w_mem_read_en  out  1  weight read strobe
w_mem_qout  in  IO_DATA_WIDTH  weight data, one-cycle latency
a_input  out  IO_DATA_WIDTH  activation operand
a_zero_flag  out  1  activation is zero (padding or value 0)
a_valid  out  1  a handshake valid
a_ready  in  1  a handshake ready
b_input  out  IO_DATA_WIDTH  weight operand
b_zero_flag  out  1  weight value is 0
b_valid  out  1  b handshake valid
b_ready  in  1  b handshake ready

Behaviour:
- Reset: FSM=IDLE; all counters 0; FIFOs empty; every output 0.
- Loop order, outer to inner: y, x, co, ky, kx, ci. Total N = H*W*COUT*K*K*CIN elements per channel.
- Element index: yi = y+ky-K/2, xi = x+kx-K/2.
  - fm addr = (yi*W + xi)*CIN + ci.
  - w addr = ((co*K + ky)*K + kx)*CIN + ci.
  - Address arithmetic is unsigned, computed in widths sufficient to avoid overflow, then truncated to port width.
- Padding (yi or xi outside the map):
  - No fm read; fm_mem_read_en=0.
  - The element still traverses the same pipeline slot, so ordering is preserved.
  - Delivered with a_zero_flag=1, a_input=0.
- Zero-skip:
  - a_zero_flag=1 also when fm data==0; b_zero_flag=1 when weight==0.
  - Data bus is forced to 0 whenever the flag is 1.
- Pipeline:
  - Issue cycle: addresses and read_en driven.
  - Next cycle: qout is captured into a per-channel 2-entry FIFO together with its flag.
  - FIFO head drives x_input/x_valid/x_zero_flag.
- Issue rule:
  - Issue when, for both channels, occupancy + inflight − pop_this_cycle < 2.
  - a and b always issue together; consumption is independent.
  - Sustains 1 element/cycle when both readies are high.
- Handshake:
  - Transfer occurs when valid && ready.
  - Once valid rises, data/flag are stable until the transfer.
  - Valid never drops without a transfer.
- FSM:
  - IDLE → STREAM on start.
  - STREAM → DRAIN the cycle after the last element issues.
  - DRAIN → IDLE when both FIFOs are empty and nothing is inflight; done pulses on that transition.
- start while running is ignored.
- Latency: start high in cycle t → first issue in t+1 → a_valid/b_valid high in t+3.
- Counters wrap innermost-first; ci wrap increments kx, etc.; final y wrap ends the issue phase.
- Reset mid-operation: immediate return to reset state, in-flight data discarded; the next start restarts from element 0.

Decomposition:
- Package conv_stream_pkg:
  - state enum {IDLE, STREAM, DRAIN}.
  - loop-index width constants derived from the parameters.
- Sub-module operand_fifo2: 2-deep show-ahead FIFO with push/pop/count and asynchronous active-low reset.
  - Instantiated twice, IO_DATA_WIDTH+1 bits wide.

Test Plan:
Small configuration used throughout: W=H=4, CIN=2, COUT=2, K=3 (N=576).
1. Reset, no stimulus → all outputs 0, running=0, no read_en for 20 cycles.
2. Readies tied high, start at cycle t:
   - a_valid/b_valid first high at t+3.
   - First a: zero_flag=1, a_input=0, and no fm read (padding corner).
   - First w addr = 0.
   - Exactly 576 transfers per channel with one valid per cycle.
   - done pulses once; running falls the same cycle.
3. Element y=1,x=1,co=0,ky=1,kx=1,ci=1 → fm addr 11, w addr 9; value matches the memory model.
4. a_ready random 50%, b_ready low for cycles 10-19:
   - Sequences on both channels match the golden model with no loss or duplication.
   - Reads stall while b is backed up.
   - FIFO occupancy never exceeds 2.
5. Weight memory word 0x0000 at addr 4 → that b transfer has b_zero_flag=1, b_input=0. fm value 0 → a_zero_flag=1.
6. start pulsed mid-stream is ignored. arst_n_in asserted at transfer 100 → all outputs 0. A new start replays from element 0 and completes all 576 transfers.
